wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback stream and result returns from the multi-cycle multiply/divide unit (MDU). Pipeline writebacks have priority. MDU results are buffered in a small queue, and a starvation timer forces a pipeline bubble so the queue always drains. The block sits between the writeback stage / MDU and the register file write port, and can publish a pending-destination scoreboard to decode.

## Interface
Parameters:
- DATA_W, default `DATA_SIZE`: register data width.
- LQ_DEPTH, default 4: MDU result queue entries; power of two, ≥2.
- STARVE_LIMIT, default 8: cycles the queue head may wait before a bubble is forced; ≥1.

Ports:
- clock  in  1  single clock for all state.
- reset  in  1  asynchronous, active-high reset.
- pipe_valid  in  1  pipeline writeback request; driven from WB_WEenable.
- pipe_dest  in  5  pipeline destination register.
- pipe_value  in  DATA_W  pipeline write data.
- mdu_valid  in  1  MDU result valid.
- mdu_ready  out  1  queue can accept; equals !full.
- mdu_dest  in  5  MDU destination register.
- mdu_value  in  DATA_W  MDU result.
- stall_req  out  1  request one pipeline bubble; registered.
- rf_we  out  1  register-file write enable; registered.
- rf_waddr  out  5  register-file write address; registered.
- rf_wdata  out  DATA_W  register-file write data; registered.
- busy_mask  out  32  bit r set while any queued MDU entry targets r.
- err_collide  out  1  sticky flag: pipe_valid seen during a forced slot.

## Operation
- Queue: FIFO of {dest, value}.
  - Push when mdu_valid && mdu_ready.
  - No push while full, even if a pop happens in the same cycle.
- State machine, states NORMAL, STALL, FORCE:
  - NORMAL: grant pipe if pipe_valid; otherwise pop the queue head if the queue is non-empty. Go to STALL when age == STARVE_LIMIT and the queue is non-empty.
  - STALL: stall_req = 1. Same grant rule as NORMAL. Always go to FORCE next.
  - FORCE: pop the queue head unconditionally. Upstream contract: pipe_valid = 0 here. If pipe_valid = 1 anyway, the pipe still wins, the head is not popped, and err_collide is set. Always go to NORMAL next.
- Age counter:
  - Counts cycles in which the queue is non-empty and the head is not popped.
  - Clears on every pop and whenever the queue is empty.
  - Saturates at STARVE_LIMIT.
- Destination 0:
  - A granted write to r0 yields rf_we = 0.
  - A queued r0 entry is still popped, i.e. consumed silently.
- busy_mask is the OR of one-hot(dest) over valid queue entries. Bit 0 is always 0.

## Timing
- Reset values:
  - state NORMAL; queue empty; age 0.
  - stall_req, rf_we, err_collide = 0.
  - rf_waddr = 0, rf_wdata = 0, busy_mask = 0.
  - mdu_ready = 1.
- Pipe request in cycle t → rf_* driven after edge t+1 (1-cycle latency).
- MDU push at edge k → head in cycle k → earliest rf write visible after edge k+1.
- Forced drain: age reaches STARVE_LIMIT in cycle t → stall_req high in cycle t+1 → FORCE in t+2 → write visible after edge t+3.
- rf_we is high for exactly one cycle per grant. Back-to-back grants are allowed.
- Reset asserted mid-operation: queued entries are discarded and no write is issued. err_collide clears only on reset.

## Configuration
- WB_ARB_SCOREBOARD_EN defined: busy_mask is computed as above.
- WB_ARB_SCOREBOARD_EN undefined: busy_mask tied to 0 and its logic removed. Decode must then interlock on MDU operations by other means.

## Structure
- Package wb_arb_pkg:
  - wb_arb_state_e (NORMAL/STALL/FORCE).
  - rf_wr_t struct {dest[4:0], value[DATA_W-1:0]}.
  - REG_ZERO constant.
- Sub-module wb_lq_fifo: parameterised LQ_DEPTH circular FIFO with push/pop/full/empty and an entry-valid vector, which feeds busy_mask.

## Test plan
- Reset → all outputs 0, mdu_ready = 1. Assert reset while 3 entries are queued → queue empty, no rf_we.
- pipe_valid with dest 5, value 0x1234 → rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234 one cycle later. Dest 0 → rf_we = 0.
- MDU pushes dest 7, value 0xAA while the pipe is idle → written 2 cycles after push; busy_mask[7] high for exactly 1 cycle (macro on), 0 throughout (macro off).
- pipe_valid held continuously, MDU pushes one entry:
  - stall_req high once age hits 8.
  - Bench drops pipe_valid in the next cycle → MDU entry written.
  - Age returns to 0.
- Same as the previous scenario, but pipe_valid is kept high in FORCE → pipe written, entry retained, err_collide = 1 and stays 1.
- Fill 4 entries with the pipe busy → mdu_ready = 0. A 5th mdu_valid is not accepted. Pops restore ready. Entries are written in FIFO order.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the writeback port arbiter.
//   wb_arb_state_e : arbiter FSM states (NORMAL / STALL / FORCE)
//   rf_wr_t        : one register-file write {dest, value} at the default width
//   REG_ZERO       : architectural zero register; writes to it are dropped
//   dest_onehot    : one-hot decode of a destination, bit 0 always clear
// `DATA_SIZE gives the default register data width (32 if not defined).
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package wb_arb_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    STALL  = 2'd1,
    FORCE  = 2'd2
  } wb_arb_state_e;

  typedef struct packed {
    logic [4:0]             dest;
    logic [`DATA_SIZE-1:0]  value;
  } rf_wr_t;

  // r0 never reports busy: it is hardwired, so decode never waits on it.
  function automatic logic [31:0] dest_onehot(input logic [4:0] d);
    logic [31:0] m;
    m    = 32'd1 << d;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/wb_lq_fifo.sv
// wb_lq_fifo: circular FIFO holding MDU results waiting for the write port.
// Ports:
//   clock, reset  : clock, asynchronous active-high reset (empties the FIFO)
//   push, din     : write din at the tail (ignored while full)
//   pop, dout     : dout is the head entry; pop advances past it (ignored while empty)
//   full, empty   : occupancy flags
//   entry_valid   : one bit per storage slot, set while that slot holds live data
//   entries       : all storage slots flattened, slot i at [i*W +: W]
module wb_lq_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [W-1:0]       din,
  input  logic               pop,
  output logic [W-1:0]       dout,
  output logic               full,
  output logic               empty,
  output logic [DEPTH-1:0]   entry_valid,
  output logic [DEPTH*W-1:0] entries
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit separates the full and empty cases when indices match.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign entries[i*W +: W] = mem[i];
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Set and clear never hit the same slot: that needs full (no push) or empty (no pop).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      entry_valid <= '0;
    end else begin
      if (do_push) begin
        wr_ptr                          <= wr_ptr + 1'b1;
        entry_valid[wr_ptr[AW-1:0]]     <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr                          <= rd_ptr + 1'b1;
        entry_valid[rd_ptr[AW-1:0]]     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline
// writeback stream (always wins) and queued MDU results. A starvation timer
// on the queue head requests one pipeline bubble so the queue always drains.
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   pipe_valid/dest/value : pipeline writeback request (no backpressure)
//   mdu_valid/dest/value  : MDU result; mdu_ready = queue not full
//   stall_req             : one-cycle bubble request (registered)
//   rf_we/waddr/wdata     : register-file write port (registered)
//   busy_mask             : bit r set while a queued MDU entry targets r
//   err_collide           : sticky, pipe_valid seen in a forced-drain slot
// Build option: define WB_ARB_SCOREBOARD_EN to compute busy_mask; when it is
// undefined busy_mask is tied to zero.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W       = `DATA_SIZE,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pipe_valid,
  input  logic [4:0]        pipe_dest,
  input  logic [DATA_W-1:0] pipe_value,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [4:0]        mdu_dest,
  input  logic [DATA_W-1:0] mdu_value,
  output logic              stall_req,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       busy_mask,
  output logic              err_collide
);

  localparam int ENTRY_W = 5 + DATA_W;
  localparam int AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  wb_arb_state_e           state;
  logic [AGE_W-1:0]        age;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [ENTRY_W-1:0]      head;
  logic [LQ_DEPTH-1:0]     entry_valid;
  logic [LQ_DEPTH*ENTRY_W-1:0] entries;
  logic                    grant;
  logic                    collide;
  logic [4:0]              g_dest;
  logic [DATA_W-1:0]       g_value;

  // MDU handshake: a result transfers on a clock edge where mdu_valid and
  // mdu_ready are both high. mdu_ready depends only on registered occupancy,
  // so a pop in the same cycle does not make room for a push.
  assign mdu_ready = !full;
  assign push      = mdu_valid && !full;

  wb_lq_fifo #(
    .W     (ENTRY_W),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .din         ({mdu_dest, mdu_value}),
    .pop         (pop),
    .dout        (head),
    .full        (full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entries     (entries)
  );

  // The pipe wins in every state, including FORCE (where it should be idle).
  // Otherwise the queue head is consumed, even when it targets r0.
  always_comb begin
    pop     = 1'b0;
    grant   = 1'b0;
    collide = 1'b0;
    g_dest  = head[ENTRY_W-1 -: 5];
    g_value = head[DATA_W-1:0];
    if (pipe_valid) begin
      grant   = 1'b1;
      g_dest  = pipe_dest;
      g_value = pipe_value;
      collide = (state == FORCE);
    end else if (!empty) begin
      grant = 1'b1;
      pop   = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= NORMAL;
      age         <= '0;
      stall_req   <= 1'b0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      err_collide <= 1'b0;
    end else begin
      // Age of the waiting head; saturates so a collided FORCE retries at once.
      if (empty || pop)          age <= '0;
      else if (age != AGE_MAX)   age <= age + 1'b1;

      stall_req <= 1'b0;
      case (state)
        NORMAL: begin
          if (!empty && (age == AGE_MAX)) begin
            state     <= STALL;
            stall_req <= 1'b1;
          end
        end
        STALL:   state <= FORCE;
        FORCE:   state <= NORMAL;
        default: state <= NORMAL;
      endcase

      rf_we <= grant && (g_dest != REG_ZERO);
      if (grant) begin
        rf_waddr <= g_dest;
        rf_wdata <= g_value;
      end
      if (collide) err_collide <= 1'b1;
    end
  end

`ifdef WB_ARB_SCOREBOARD_EN
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (entry_valid[i])
        busy_mask = busy_mask | dest_onehot(entries[i*ENTRY_W + DATA_W +: 5]);
    end
  end
`else
  logic unused_sb;
  assign unused_sb = ^{entry_valid, entries};
  assign busy_mask = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: randomized and directed stimulus for wb_port_arbiter.
// The reference model is a plain queue of pending MDU results plus the rule
// "pipe first, else oldest queued result"; every predicted write is stamped
// with the cycle it must appear in and checked by an independent monitor.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int DW    = `DATA_SIZE;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  localparam int EW    = 16 + 5 + DW;
`ifdef WB_ARB_SCOREBOARD_EN
  localparam bit SB_ON = 1'b1;
`else
  localparam bit SB_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clock;
  logic          reset;
  logic          pipe_valid;
  logic [4:0]    pipe_dest;
  logic [DW-1:0] pipe_value;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [4:0]    mdu_dest;
  logic [DW-1:0] mdu_value;
  logic          stall_req;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   busy_mask;
  logic          err_collide;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  wb_port_arbiter #(
    .DATA_W       (DW),
    .LQ_DEPTH     (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pipe_valid  (pipe_valid),
    .pipe_dest   (pipe_dest),
    .pipe_value  (pipe_value),
    .mdu_valid   (mdu_valid),
    .mdu_ready   (mdu_ready),
    .mdu_dest    (mdu_dest),
    .mdu_value   (mdu_value),
    .stall_req   (stall_req),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy_mask   (busy_mask),
    .err_collide (err_collide)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [EW-1:0] exp_q[$];   // {cycle[15:0], dest, value} of each expected write
  rf_wr_t        model_q[$]; // MDU results the model believes are queued
  logic          s_stall, s_err, s_ready;
  logic [31:0]   s_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    if (SB_ON) begin
      foreach (model_q[i]) m[model_q[i].dest] = 1'b1;
      m[0] = 1'b0;
    end
    return m;
  endfunction

  // ---------------- driver ----------------
  // One cycle: sample outputs mid-cycle, drive inputs, advance the model.
  task automatic step(input logic pv, input logic [4:0] pd, input logic [DW-1:0] pval,
                      input logic mv, input logic [4:0] md, input logic [DW-1:0] mval);
    int     sz;
    rf_wr_t e;
    @(negedge clock);
    s_stall = stall_req;
    s_err   = err_collide;
    s_ready = mdu_ready;
    s_busy  = busy_mask;
    check("mdu_ready", mdu_ready, (model_q.size() < DEPTH));
    check("busy_mask", busy_mask, model_busy());
    pipe_valid = pv;
    pipe_dest  = pd;
    pipe_value = pval;
    mdu_valid  = mv;
    mdu_dest   = md;
    mdu_value  = mval;
    sz = model_q.size();
    if (pv) begin
      if (pd != 5'd0) exp_q.push_back({16'(cyc + 1), pd, pval});
    end else if (sz > 0) begin
      e = model_q.pop_front();
      if (e.dest != 5'd0) exp_q.push_back({16'(cyc + 1), e.dest, e.value});
    end
    if (mv && (sz < DEPTH)) model_q.push_back('{dest: md, value: mval});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] f;
    forever begin
      @(posedge clock);
      #1;
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rf_write_unexpected: got addr %0d data 0x%0h, expected no write (cycle %0d)",
                   rf_waddr, rf_wdata, cyc);
        end else begin
          f = exp_q.pop_front();
          check("rf_write", {16'(cyc), rf_waddr, rf_wdata}, f);
        end
      end else if (exp_q.size() > 0) begin
        f = exp_q[0];
        if (f[EW-1 -: 16] <= 16'(cyc)) begin
          void'(exp_q.pop_front());
          n_checks++;
          $display("FAIL rf_write_missing: got rf_we 0, expected write addr %0d data 0x%0h (cycle %0d)",
                   f[DW +: 5], f[DW-1:0], cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequences ----------------
  task automatic starve(input logic keep_pipe);
    step(1'b1, 5'd3, 32'h100, 1'b1, 5'd9, 32'hBB);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 5'd3, DW'(32'h100 + i), 1'b0, 5'd0, '0);
      check("stall_req_timing", s_stall, (i == 10));
    end
    step(keep_pipe, 5'd4, 32'h200, 1'b0, 5'd0, '0);
    check("stall_req_force", s_stall, 1'b0);
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    check("err_collide", s_err, keep_pipe);
  endtask

  initial begin
    logic pv, mv;
    reset      = 1'b1;
    pipe_valid = 1'b0;
    pipe_dest  = '0;
    pipe_value = '0;
    mdu_valid  = 1'b0;
    mdu_dest   = '0;
    mdu_value  = '0;
    s_stall    = 1'b0;
    s_err      = 1'b0;
    s_ready    = 1'b1;
    s_busy     = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_rf_we", rf_we, 1'b0);
    check("reset_rf_waddr", rf_waddr, 5'd0);
    check("reset_rf_wdata", rf_wdata, '0);
    check("reset_stall_req", stall_req, 1'b0);
    check("reset_err_collide", err_collide, 1'b0);
    check("reset_busy_mask", busy_mask, 32'd0);
    check("reset_mdu_ready", mdu_ready, 1'b1);
    reset = 1'b0;

    // Pipe writes, including one to r0 that must be dropped.
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, '0);
    step(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, '0);
    step(1'b1, 5'd31, 32'hCAFE, 1'b0, 5'd0, '0);
    idle(2);

    // Single MDU result with the pipe idle.
    step(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'hAA);
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    check("busy7_queued", s_busy[7], SB_ON);
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    check("busy7_cleared", s_busy[7], 1'b0);
    idle(2);

    // Starvation with the contract respected, twice from a clean start.
    starve(1'b0);
    idle(3);
    starve(1'b0);
    idle(3);

    // Fill the queue behind a busy pipe, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 5'd0, '0, 1'b1, 5'(10 + i), DW'(32'h1000 + i));
    step(1'b1, 5'd0, '0, 1'b1, 5'd20, 32'hDEAD);
    check("ready_when_full", s_ready, 1'b0);
    step(1'b0, 5'd0, '0, 1'b1, 5'd21, 32'hBEEF);
    check("ready_full_with_pop", s_ready, 1'b0);
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    check("ready_after_pop", s_ready, 1'b1);
    idle(6);

    // Random traffic; FORCE cycles see pipe_valid low.
    for (int n = 0; n < 400; n++) begin
      pv = s_stall ? 1'b0 : ($urandom_range(0, 9) < 6);
      mv = ($urandom_range(0, 1) == 1);
      step(pv, 5'($urandom_range(0, 31)), DW'($urandom),
           mv, 5'($urandom_range(0, 31)), DW'($urandom));
    end
    idle(20);
    check("err_after_random", s_err, 1'b0);

    // Contract violation in FORCE: pipe wins, entry kept, sticky error.
    starve(1'b1);
    idle(6);
    check("err_sticky", s_err, 1'b1);

    // Reset while three results are queued: all discarded, no write.
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd0, '0, 1'b1, 5'(11 + i), DW'(32'h3000 + i));
    @(negedge clock);
    reset      = 1'b1;
    pipe_valid = 1'b0;
    mdu_valid  = 1'b0;
    model_q.delete();
    @(negedge clock);
    @(negedge clock);
    check("midreset_rf_we", rf_we, 1'b0);
    check("midreset_mdu_ready", mdu_ready, 1'b1);
    check("midreset_busy", busy_mask, 32'd0);
    check("midreset_err", err_collide, 1'b0);
    check("midreset_stall", stall_req, 1'b0);
    reset = 1'b0;
    idle(5);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
